btn_debounce: RTL and testbench



---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_db_channel.sv | 87 ++++++++
 rtl/btn_debounce.sv | 65 ++++++
 tb/tb_btn_debounce.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the button debounce path.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b10,
    FALL_CHK = 2'b11
  } btn_db_state_t;

  // Number of stable clk cycles required before a debounced level may change.
  function automatic int unsigned btn_db_cycles(input int unsigned clk_hz,
                                                input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/btn_db_channel.sv
// One debounce channel: 2-FF synchroniser, stability counter and 4-state FSM.
// The debounced level is decoded from the state register only.
module btn_db_channel
  import btn_pkg::*;
#(
  parameter int unsigned CNT_MAX = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          raw,
  output logic          db,
  output btn_db_state_t state
);

  localparam int unsigned CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          ff1;
  logic          ff2;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser; ff2 is the sampled button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
    end else begin
      ff1 <= raw;
      ff2 <= ff1;
    end
  end

  // Debounce FSM: a level must hold CNT_MAX samples in a CHK state to commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      case (state)
        LOW: begin
          if (ff2) begin
            state <= RISE_CHK;
            cnt   <= '0;
          end
        end
        RISE_CHK: begin
          if (!ff2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!ff2) begin
            state <= FALL_CHK;
            cnt   <= '0;
          end
        end
        FALL_CHK: begin
          if (ff2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output is high while the committed level is high (HIGH or checking a fall).
  always_comb begin
    db = (state == HIGH) || (state == FALL_CHK);
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounces the up/down board buttons into clean levels for the edge stage.
// Optional macro BTN_DB_MUTEX_EN: forces both outputs low while both
// buttons are debounced-high.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 65_000_000,
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btnu_raw,
  input  logic btnd_raw,
  output logic btnu_db,
  output logic btnd_db
);

  localparam int unsigned CNT_MAX = btn_db_cycles(CLK_HZ, DEBOUNCE_MS);

  if (CNT_MAX < 1) begin : g_cnt_check
    $error("btn_debounce: CNT_MAX must be at least 1");
  end

  logic          db_u;
  logic          db_d;
  btn_db_state_t st_u;
  btn_db_state_t st_d;

  btn_db_channel #(.CNT_MAX(CNT_MAX)) u_ch_u (
    .clk   (clk),
    .rst   (rst),
    .raw   (btnu_raw),
    .db    (db_u),
    .state (st_u)
  );

  btn_db_channel #(.CNT_MAX(CNT_MAX)) u_ch_d (
    .clk   (clk),
    .rst   (rst),
    .raw   (btnd_raw),
    .db    (db_d),
    .state (st_d)
  );

`ifdef BTN_DB_MUTEX_EN
  logic both_active;

  // Suppress both outputs while both channels hold a committed-high level.
  always_comb begin
    both_active = st_u[1] && st_d[1];
    btnu_db     = db_u && !both_active;
    btnd_db     = db_d && !both_active;
  end
`else
  logic unused_state;

  // Pure per-channel decode; the state outputs only matter for gating.
  always_comb begin
    unused_state = ^{st_u, st_d};
    btnu_db      = db_u;
    btnd_db      = db_d;
  end
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with CNT_MAX = 10.
module tb_btn_debounce;
  import btn_pkg::*;

  localparam int unsigned CNT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnu_raw = 1'b0;
  logic btnd_raw = 1'b0;
  logic btnu_db;
  logic btnd_db;

  btn_debounce #(.CLK_HZ(1000), .DEBOUNCE_MS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .btnu_raw (btnu_raw),
    .btnd_raw (btnd_raw),
    .btnu_db  (btnu_db),
    .btnd_db  (btnd_db)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit cmp_en = 1'b0;

  // Reference model: raw history per channel, committed level and the
  // length of the current run of samples disagreeing with that level.
  logic        hu1, hu2, hd1, hd2;
  logic        lu, ld;
  int unsigned run_u, run_d;

`ifdef BTN_DB_MUTEX_EN
  localparam bit MUTEX = 1'b1;
`else
  localparam bit MUTEX = 1'b0;
`endif

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_u();
    return MUTEX ? (lu && !ld) : lu;
  endfunction

  function automatic logic exp_d();
    return MUTEX ? (ld && !lu) : ld;
  endfunction

  task automatic model_reset();
    hu1 = 1'b0; hu2 = 1'b0; hd1 = 1'b0; hd2 = 1'b0;
    lu = 1'b0; ld = 1'b0;
    run_u = 0; run_d = 0;
  endtask

  // Sample seen by the debouncer is the raw level from two edges earlier;
  // the level commits after CNT+1 consecutive disagreeing samples.
  task automatic model_chan(input logic raw, inout logic h1, inout logic h2,
                            inout int unsigned run, inout logic lvl);
    logic s;
    s  = h2;
    h2 = h1;
    h1 = raw;
    if (s !== lvl) begin
      run++;
      if (run == CNT + 1) begin
        lvl = s;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_chan(btnu_raw, hu1, hu2, run_u, lu);
      model_chan(btnd_raw, hd1, hd2, run_d, ld);
    end
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Run n edges; pin both outputs at edge CNT+2 and CNT+3 with literals.
  task automatic watch(input int n, input string nm,
                       input logic u12, input logic u13,
                       input logic d12, input logic d13);
    for (int e = 1; e <= n; e++) begin
      step();
      if (e == CNT + 2) begin
        chk({nm, "_u_e12"}, btnu_db, u12);
        chk({nm, "_d_e12"}, btnd_db, d12);
      end
      if (e == CNT + 3) begin
        chk({nm, "_u_e13"}, btnu_db, u13);
        chk({nm, "_d_e13"}, btnd_db, d13);
      end
    end
  endtask

  // Continuous comparison against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_btnu_db", btnu_db, exp_u());
      chk("model_btnd_db", btnd_db, exp_d());
    end
  end

  initial begin
    int unsigned rate;
    model_reset();
    cmp_en = 1'b1;
    steps(3);
    chk("reset_btnu_db", btnu_db, 1'b0);
    chk("reset_btnd_db", btnd_db, 1'b0);
    rst = 1'b0;

    // Clean press on up.
    btnu_raw = 1'b1;
    watch(30, "t1", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_btnd_low", btnd_db, 1'b0);
    btnu_raw = 1'b0;
    steps(20);
    chk("t1_released", btnu_db, 1'b0);

    // Bounce 1,0,1,0 every 3 cycles, then hold high.
    for (int p = 0; p < 4; p++) begin
      btnu_raw = (p % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        step();
        chk("t2_bounce", btnu_db, 1'b0);
      end
    end
    btnu_raw = 1'b1;
    watch(20, "t2", 1'b0, 1'b1, 1'b0, 1'b0);

    // Short release glitch, then real release.
    btnu_raw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_glitch", btnu_db, 1'b1);
    end
    btnu_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t3_hold", btnu_db, 1'b1);
    end
    btnu_raw = 1'b0;
    watch(20, "t3", 1'b1, 1'b0, 1'b0, 1'b0);

    // Down held; async reset mid-count between edges.
    btnd_raw = 1'b1;
    steps(8);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t4_rst_db", btnd_db, 1'b0);
    chk("t4_rst_state", dut.u_ch_d.state, LOW);
    @(negedge clk);
    rst = 1'b0;
    watch(20, "t4", 1'b0, 1'b0, 1'b0, 1'b1);
    btnd_raw = 1'b0;
    steps(20);

    // Both pressed together, then down released.
    btnu_raw = 1'b1;
    btnd_raw = 1'b1;
    watch(20, "t5", 1'b0, !MUTEX, 1'b0, !MUTEX);
    btnd_raw = 1'b0;
    watch(20, "t6", !MUTEX, 1'b1, !MUTEX, 1'b0);
    btnu_raw = 1'b0;
    steps(20);

    // Randomised bouncing with occasional asynchronous resets.
    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(3, 0))
        0:       rate = 2;
        1:       rate = 6;
        2:       rate = 30;
        default: rate = 200;
      endcase
      for (int k = 0; k < 100; k++) begin
        step();
        if ($urandom_range(rate - 1, 0) == 0) btnu_raw = ~btnu_raw;
        if ($urandom_range(rate - 1, 0) == 0) btnd_raw = ~btnd_raw;
        if ($urandom_range(399, 0) == 0) begin
          #2;
          rst = 1'b1;
          model_reset();
          #1;
          rst = 1'b0;
        end
      end
    end

    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
